// File: rtl/flex_fifo_ctrl.sv
// flex_fifo_ctrl: single-clock FIFO controller for the JTAG flex FIFO.
// Owns the write/read pointers and the occupancy count, drives an external
// sync-write / comb-read memory, and presents a first-word-fall-through
// push/pop port. The head word is the memory's combinational read data.
//
// Optional feature: define FLEX_FIFO_ERR_FLAGS_EN to add sticky overflow and
// underflow outputs. Without it, ignored requests are silently dropped.
module flex_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_LEVEL   = 12
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         clear,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        wdata_in,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        rdata_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
`ifdef FLEX_FIFO_ERR_FLAGS_EN
    output logic                         overflow,
    output logic                         underflow,
`endif
    output logic                         mem_wclk,
    output logic                         mem_wclk_en,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [ADDR_WIDTH-1:0]        mem_waddr,
    output logic [ADDR_WIDTH-1:0]        mem_raddr,
    input  logic [DATA_WIDTH-1:0]        mem_rdata
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic is_full;
    logic is_empty;
    logic wr_ok;
    logic rd_ok;

    // Status flags decode straight from the registered count.
    always_comb begin
        is_full  = (count_q == CNT_FULL);
        is_empty = (count_q == '0);
        // A push into a full FIFO is accepted only when a pop frees the head
        // slot in the same cycle; the write then lands on the slot being read.
        wr_ok    = push & (~is_full | pop);
        rd_ok    = pop & ~is_empty;
    end

    // Next-state for pointers and occupancy; clear overrides push and pop.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // Pointers wrap at DEPTH-1 explicitly, so DEPTH need not be a power of two.
            if (wr_ok) begin
                wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
            end
            if (rd_ok) begin
                rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

`ifdef FLEX_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags: set on dropped requests, cleared only by clear or reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push & is_full & ~pop) begin
                overflow_q <= 1'b1;
            end
            if (pop & is_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign full        = is_full;
    assign empty       = is_empty;
    assign almost_full = (count_q >= CNT_AF);
    assign count       = count_q;

    // The memory shares our clock and samples its write port on the same edge
    // that advances wptr. The write enable is also held off while nRST is low
    // so a push held across reset cannot corrupt memory.
    assign mem_wclk    = CLK;
    assign mem_wclk_en = wr_ok & ~clear & nRST;
    assign mem_wdata   = wdata_in;
    assign mem_waddr   = ADDR_WIDTH'(wptr_q);
    assign mem_raddr   = ADDR_WIDTH'(rptr_q);

    // First-word-fall-through: head word comes combinationally from memory.
    assign rdata_out   = mem_rdata;

endmodule

// File: tb/tb_flex_fifo_ctrl.sv
// Self-checking bench for flex_fifo_ctrl (DEPTH=16, AF_LEVEL=12) with a
// behavioural memory and a queue-based reference model of FIFO contents.
// Honours FLEX_FIFO_ERR_FLAGS_EN for the optional overflow/underflow outputs.
module tb_flex_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int AFL   = 12;
    localparam int CW    = 5;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        clear;
    logic        push;
    logic        pop;
    logic [7:0]  wdata_in;
    logic [7:0]  rdata_out;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic [CW-1:0] count;
`ifdef FLEX_FIFO_ERR_FLAGS_EN
    logic        overflow;
    logic        underflow;
`endif
    logic        mem_wclk;
    logic        mem_wclk_en;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_waddr;
    logic [31:0] mem_raddr;
    logic [7:0]  mem_rdata;

    flex_fifo_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(32),
        .DEPTH     (DEPTH),
        .AF_LEVEL  (AFL)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .clear      (clear),
        .push       (push),
        .wdata_in   (wdata_in),
        .pop        (pop),
        .rdata_out  (rdata_out),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .count      (count),
`ifdef FLEX_FIFO_ERR_FLAGS_EN
        .overflow   (overflow),
        .underflow  (underflow),
`endif
        .mem_wclk   (mem_wclk),
        .mem_wclk_en(mem_wclk_en),
        .mem_wdata  (mem_wdata),
        .mem_waddr  (mem_waddr),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    // Sync-write, comb-read memory.
    logic [7:0] mem_array [DEPTH];
    always @(posedge CLK) begin
        if (mem_wclk_en) mem_array[mem_waddr[3:0]] <= mem_wdata;
    end
    assign mem_rdata = mem_array[mem_raddr[3:0]];

    // Reference model: queue of stored words plus accepted-transfer totals.
    logic [7:0] model_q[$];
    int  wr_tot, rd_tot;
    bit  ovf_m, unf_m;

    int  vectors = 0;
    int  errors  = 0;

    // Per-cycle observations taken just before the active edge.
    bit         exp_wen, obs_wen, head_valid;
    logic [7:0] exp_head, obs_head;
    logic [31:0] obs_waddr, exp_waddr;

    task automatic model_reset();
        model_q.delete();
        wr_tot = 0;
        rd_tot = 0;
        ovf_m  = 0;
        unf_m  = 0;
    endtask

    // Drive one cycle of stimulus, sample pre-edge outputs, advance the model.
    task automatic cycle(input bit p, input bit r, input logic [7:0] d, input bit c);
        bit full_m, empty_m, wr, rd;
        @(negedge CLK);
        push = p; pop = r; wdata_in = d; clear = c;
        #1;
        full_m     = (model_q.size() == DEPTH);
        empty_m    = (model_q.size() == 0);
        wr         = p && (!full_m || r);
        rd         = r && !empty_m;
        exp_wen    = wr && !c;
        obs_wen    = mem_wclk_en;
        head_valid = !empty_m;
        exp_head   = empty_m ? 8'h00 : model_q[0];
        obs_head   = rdata_out;
        obs_waddr  = mem_waddr;
        exp_waddr  = 32'(wr_tot % DEPTH);
        @(posedge CLK);
        if (c) begin
            model_reset();
        end else begin
            if (p && full_m && !r) ovf_m = 1;
            if (r && empty_m) unf_m = 1;
            if (rd) begin
                void'(model_q.pop_front());
                rd_tot++;
            end
            if (wr) begin
                model_q.push_back(d);
                wr_tot++;
            end
        end
        #1;
        push = 0; pop = 0; clear = 0;
    endtask

    task automatic test_reset();
        nRST = 0; push = 0; pop = 0; clear = 0; wdata_in = 8'h00;
        model_reset();
        #12;
        vectors++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        vectors++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        vectors++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b expected 0", almost_full); end
        vectors++; if (mem_wclk_en !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b expected 0", mem_wclk_en); end
        vectors++; if (mem_waddr !== 32'd0) begin errors++; $display("FAIL reset_waddr: got %0h expected 0", mem_waddr); end
        vectors++; if (mem_raddr !== 32'd0) begin errors++; $display("FAIL reset_raddr: got %0h expected 0", mem_raddr); end
`ifdef FLEX_FIFO_ERR_FLAGS_EN
        vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_errflags: got %b%b expected 00", overflow, underflow); end
`endif
        @(posedge CLK); #1;
        vectors++; if (mem_wclk !== 1'b1) begin errors++; $display("FAIL wclk_high: got %b expected 1", mem_wclk); end
        @(negedge CLK); #1;
        vectors++; if (mem_wclk !== 1'b0) begin errors++; $display("FAIL wclk_low: got %b expected 0", mem_wclk); end
        nRST = 1;
    endtask

    task automatic test_single();
        cycle(1, 0, 8'hA1, 0);
        vectors++; if (obs_wen !== 1'b1) begin errors++; $display("FAIL single_wen: got %b expected 1", obs_wen); end
        vectors++; if (count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
        vectors++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty: got %b expected 0", empty); end
        vectors++; if (rdata_out !== 8'hA1) begin errors++; $display("FAIL single_head: got %0h expected a1", rdata_out); end
        cycle(0, 1, 8'h00, 0);
        vectors++; if (obs_head !== 8'hA1) begin errors++; $display("FAIL single_pop_data: got %0h expected a1", obs_head); end
        vectors++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL single_after_pop: got empty=%b count=%0d expected 1/0", empty, count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 8'(i), 0);
            vectors++; if (count !== CW'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count, i + 1); end
            vectors++; if (almost_full !== ((i + 1) >= AFL)) begin errors++; $display("FAIL fill_af: got %b at count %0d", almost_full, i + 1); end
            vectors++; if (full !== ((i + 1) == DEPTH)) begin errors++; $display("FAIL fill_full: got %b at count %0d", full, i + 1); end
        end
        cycle(1, 0, 8'hFF, 0);
        vectors++; if (obs_wen !== 1'b0) begin errors++; $display("FAIL overfill_wen: got %b expected 0", obs_wen); end
        vectors++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL overfill_state: got count=%0d full=%b expected 16/1", count, full); end
`ifdef FLEX_FIFO_ERR_FLAGS_EN
        vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b expected 1", overflow); end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, 8'h00, 0);
            vectors++; if (obs_head !== 8'(i)) begin errors++; $display("FAIL drain_data: got %0h expected %0h", obs_head, i); end
        end
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
    endtask

    task automatic test_wrap();
        bit saw_wrap = 0;
        logic [31:0] prev = 32'hFFFF_FFFF;
        cycle(0, 0, 8'h00, 1);
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < ((rep == 2) ? 8 : 10); i++) begin
                cycle(1, 0, 8'($urandom), 0);
                vectors++; if (obs_waddr !== exp_waddr) begin errors++; $display("FAIL wrap_waddr: got %0h expected %0h", obs_waddr, exp_waddr); end
                if (prev == 32'd15 && obs_waddr == 32'd0) saw_wrap = 1;
                prev = obs_waddr;
            end
            if (rep < 2) begin
                for (int i = 0; i < 10; i++) begin
                    cycle(0, 1, 8'h00, 0);
                    vectors++; if (obs_head !== exp_head) begin errors++; $display("FAIL wrap_data: got %0h expected %0h", obs_head, exp_head); end
                end
            end
        end
        vectors++; if (saw_wrap !== 1'b1) begin errors++; $display("FAIL wrap_seen: got %b expected 1", saw_wrap); end
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 8'h00, 0);
            vectors++; if (obs_head !== exp_head) begin errors++; $display("FAIL wrap_tail_data: got %0h expected %0h", obs_head, exp_head); end
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] old_head;
        cycle(0, 0, 8'h00, 1);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 8'($urandom_range(0, 8'h54)), 0);
        old_head = model_q[0];
        cycle(1, 1, 8'h55, 0);
        vectors++; if (obs_head !== old_head) begin errors++; $display("FAIL fullpp_head: got %0h expected %0h", obs_head, old_head); end
        vectors++; if (obs_wen !== 1'b1) begin errors++; $display("FAIL fullpp_wen: got %b expected 1", obs_wen); end
        vectors++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL fullpp_count: got %0d expected 16", count); end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, 8'h00, 0);
            vectors++; if (obs_head !== exp_head) begin errors++; $display("FAIL fullpp_drain: got %0h expected %0h", obs_head, exp_head); end
        end
        vectors++; if (obs_head !== 8'h55) begin errors++; $display("FAIL fullpp_last: got %0h expected 55", obs_head); end
    endtask

    task automatic test_empty_push_pop();
        cycle(0, 0, 8'h00, 1);
        cycle(1, 1, 8'h33, 0);
        vectors++; if (count !== 5'd1 || empty !== 1'b0) begin errors++; $display("FAIL emptypp_count: got %0d expected 1", count); end
        vectors++; if (rdata_out !== 8'h33) begin errors++; $display("FAIL emptypp_head: got %0h expected 33", rdata_out); end
`ifdef FLEX_FIFO_ERR_FLAGS_EN
        vectors++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_flag: got %b expected 1", underflow); end
`endif
        cycle(0, 1, 8'h00, 0);
    endtask

    task automatic test_clear_and_reset();
        for (int i = 0; i < 7; i++) cycle(1, 0, 8'($urandom), 0);
        vectors++; if (count !== 5'd7) begin errors++; $display("FAIL clear_pre_count: got %0d expected 7", count); end
        cycle(1, 0, 8'hAA, 1);
        vectors++; if (obs_wen !== 1'b0) begin errors++; $display("FAIL clear_wen: got %b expected 0", obs_wen); end
        vectors++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL clear_state: got count=%0d empty=%b expected 0/1", count, empty); end
        vectors++; if (mem_waddr !== 32'd0 || mem_raddr !== 32'd0) begin errors++; $display("FAIL clear_ptrs: got %0h/%0h expected 0/0", mem_waddr, mem_raddr); end
`ifdef FLEX_FIFO_ERR_FLAGS_EN
        vectors++; if (underflow !== 1'b0) begin errors++; $display("FAIL clear_errflags: got %b expected 0", underflow); end
`endif
        for (int i = 0; i < 13; i++) cycle(1, 0, 8'($urandom), 0);
        // Assert reset asynchronously in the middle of a push cycle.
        @(negedge CLK);
        push = 1; wdata_in = 8'h77;
        #2;
        nRST = 0;
        #1;
        vectors++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL midreset_state: got count=%0d empty=%b expected 0/1", count, empty); end
        vectors++; if (almost_full !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL midreset_flags: got af=%b full=%b expected 0/0", almost_full, full); end
        vectors++; if (mem_wclk_en !== 1'b0) begin errors++; $display("FAIL midreset_wen: got %b expected 0", mem_wclk_en); end
        vectors++; if (mem_waddr !== 32'd0 || mem_raddr !== 32'd0) begin errors++; $display("FAIL midreset_ptrs: got %0h/%0h expected 0/0", mem_waddr, mem_raddr); end
        push = 0;
        model_reset();
        @(negedge CLK);
        nRST = 1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            bit p, r, c;
            // Alternate fill-biased and drain-biased phases to reach both extremes.
            if ((n / 60) % 2 == 0) begin
                p = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0);
            end else begin
                p = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0);
            end
            c = ($urandom_range(0, 63) == 0);
            cycle(p, r, 8'($urandom), c);
            vectors++; if (obs_wen !== exp_wen) begin errors++; $display("FAIL rnd_wen: cyc %0d got %b expected %b", n, obs_wen, exp_wen); end
            if (head_valid) begin
                vectors++; if (obs_head !== exp_head) begin errors++; $display("FAIL rnd_head: cyc %0d got %0h expected %0h", n, obs_head, exp_head); end
            end
            vectors++; if (count !== CW'(model_q.size())) begin errors++; $display("FAIL rnd_count: cyc %0d got %0d expected %0d", n, count, model_q.size()); end
            vectors++; if (empty !== (model_q.size() == 0) || full !== (model_q.size() == DEPTH)) begin errors++; $display("FAIL rnd_flags: cyc %0d got e=%b f=%b size %0d", n, empty, full, model_q.size()); end
            vectors++; if (almost_full !== (model_q.size() >= AFL)) begin errors++; $display("FAIL rnd_af: cyc %0d got %b size %0d", n, almost_full, model_q.size()); end
            vectors++; if (mem_waddr !== 32'(wr_tot % DEPTH) || mem_raddr !== 32'(rd_tot % DEPTH)) begin errors++; $display("FAIL rnd_ptrs: cyc %0d got %0h/%0h expected %0h/%0h", n, mem_waddr, mem_raddr, wr_tot % DEPTH, rd_tot % DEPTH); end
`ifdef FLEX_FIFO_ERR_FLAGS_EN
            vectors++; if (overflow !== ovf_m || underflow !== unf_m) begin errors++; $display("FAIL rnd_errflags: cyc %0d got %b%b expected %b%b", n, overflow, underflow, ovf_m, unf_m); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_full_push_pop();
        test_empty_push_pop();
        test_clear_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
